// File: rtl/display_source_select.sv
// Pushbutton-driven 4:1 display source selector with debounce and a 13-bit clamp.
// Define DISP_HOLD_EN to refresh num/ovf periodically; by default they follow the source every cycle.
module display_source_select #(
  parameter int DB_CYCLES   = 500000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  output logic [12:0] num,
  output logic [1:0]  src_sel,
  output logic        ovf
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} db_state_t;

  logic            sync_p0, sync_p1;
  db_state_t       state, state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic            adv;
  logic [31:0]     sel_src;
  logic            sample;

  // {ovf, num}: values above the 13-bit display range saturate at 8191.
  function automatic logic [13:0] clamp13(input logic [31:0] v);
    if (v > 32'd8191) clamp13 = {1'b1, 13'h1FFF};
    else              clamp13 = {1'b0, v[12:0]};
  endfunction

  // Stage p0/p1: two-flop synchronizer for the raw button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_next;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE_LOW;
      db_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        db_cnt <= '0;
      else if (state == WAIT_HIGH || state == WAIT_LOW)
        db_cnt <= db_cnt + 1'b1;
    end
  end

  // Only the rising-side acceptance advances; release is debounced silently.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    unique case (state)
      IDLE_LOW:  if (sync_p1) state_nxt = WAIT_HIGH;
      WAIT_HIGH: begin
        if (!sync_p1) state_nxt = IDLE_LOW;
        else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE_HIGH;
          adv       = 1'b1;
        end
      end
      IDLE_HIGH: if (!sync_p1) state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (sync_p1) state_nxt = IDLE_HIGH;
        else if (db_cnt == DB_LAST) state_nxt = IDLE_LOW;
      end
      default:   state_nxt = IDLE_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      src_sel <= 2'd0;
    else if (adv) src_sel <= src_sel + 2'd1;
  end

  always_comb begin
    sel_src = src0;
    unique case (src_sel)
      2'd0: sel_src = src0;
      2'd1: sel_src = src1;
      2'd2: sel_src = src2;
      2'd3: sel_src = src3;
      default: sel_src = src0;
    endcase
  end

`ifdef DISP_HOLD_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              load_pend;
  logic              hold_tc;

  assign hold_tc = (hold_cnt == HOLD_LAST);
  // A terminal count that lands on a selection change is dropped; load_pend samples the new source.
  assign sample  = load_pend || (hold_tc && !adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      load_pend <= 1'b1;
    end else begin
      load_pend <= adv;
      if (adv || hold_tc) hold_cnt <= '0;
      else                hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign sample = 1'b1;
`endif

  // Stage p2: registered clamped display value
  always_ff @(posedge clk) begin
    if (rst) begin
      num <= '0;
      ovf <= 1'b0;
    end else if (sample) begin
      {ovf, num} <= clamp13(sel_src);
    end
  end

endmodule

// File: tb/tb_display_source_select.sv
// Directed bench for display_source_select with DB_CYCLES=4, HOLD_CYCLES=8.
// Expectations follow whichever DISP_HOLD_EN setting the design is built with.
module tb_display_source_select;

  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic [31:0] src0 = '0, src1 = '0, src2 = '0, src3 = '0;
  logic [12:0] num;
  logic [1:0]  src_sel;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  display_source_select #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .num(num), .src_sel(src_sel), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean_press();
    btn_next = 1'b1;
    step(10);
    btn_next = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; src0 = 32'd1234; src1 = 32'd77; src2 = 32'd20000; src3 = 32'd3;
    step(2);
    checks++; if (num !== 13'd0) begin errors++; $display("FAIL reset_num got %0d want 0", num); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (src_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", src_sel); end
    rst = 1'b0;
    step(2);
    checks++; if (num !== 13'd1234) begin errors++; $display("FAIL post_reset_num got %0d want 1234", num); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL post_reset_ovf got %0b want 0", ovf); end
  endtask

  task automatic test_debounce();
    logic [1:0] prev;
    int changes;
    bit pend;
    prev = src_sel; changes = 0; pend = 0;
    for (int i = 0; i < 4 + 10 + 20; i++) begin
      if (i < 4)       btn_next = (i % 2 == 0);
      else if (i < 14) btn_next = 1'b1;
      else             btn_next = 1'b0;
      step(i < 4 ? 2 : 1);
      if (pend) begin
        checks++; if (num !== 13'd77) begin errors++; $display("FAIL adv_num got %0d want 77", num); end
        pend = 0;
      end
      if (src_sel !== prev) begin
        changes++; prev = src_sel; pend = 1;
      end
    end
    checks++; if (changes != 1) begin errors++; $display("FAIL debounce_count got %0d want 1", changes); end
    checks++; if (src_sel !== 2'd1) begin errors++; $display("FAIL debounce_sel got %0d want 1", src_sel); end
  endtask

  task automatic test_clamp();
    int t;
    btn_next = 1'b1;
    t = 0;
    while (src_sel !== 2'd2 && t < 20) begin step(1); t++; end
    btn_next = 1'b0;
    checks++; if (src_sel !== 2'd2) begin errors++; $display("FAIL clamp_sel got %0d want 2", src_sel); end
    step(1);
    checks++; if (num !== 13'd8191 || ovf !== 1'b1) begin errors++; $display("FAIL clamp_20000 got %0d/%0b want 8191/1", num, ovf); end
    src2 = 32'd500;
`ifdef DISP_HOLD_EN
    for (int k = 2; k < 8; k++) begin
      step(1);
      checks++; if (num !== 13'd8191) begin errors++; $display("FAIL hold_stays k=%0d got %0d want 8191", k, num); end
    end
`endif
    step(1);
    checks++; if (num !== 13'd500 || ovf !== 1'b0) begin errors++; $display("FAIL refresh_500 got %0d/%0b want 500/0", num, ovf); end
    step(15);
  endtask

  task automatic test_boundary();
    logic [31:0] vin  [5] = '{32'd8191, 32'd8192, 32'hFFFF_FFFF, 32'd8190, 32'd0};
    logic [12:0] vnum [5] = '{13'd8191, 13'd8191, 13'd8191, 13'd8190, 13'd0};
    logic        vovf [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      src2 = vin[i];
      step(HOLD + 2);
      checks++;
      if (num !== vnum[i] || ovf !== vovf[i]) begin
        errors++; $display("FAIL boundary in=%0d got %0d/%0b want %0d/%0b", vin[i], num, ovf, vnum[i], vovf[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] want [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] prev;
    int changes;
    for (int i = 0; i < 5; i++) begin
      clean_press();
      checks++; if (src_sel !== want[i]) begin errors++; $display("FAIL wrap_%0d got %0d want %0d", i, src_sel, want[i]); end
    end
    prev = src_sel; changes = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 100) btn_next = 1'b0;
      step(1);
      if (src_sel !== prev) begin changes++; prev = src_sel; end
    end
    checks++; if (changes != 1 || src_sel !== 2'd0) begin errors++; $display("FAIL held_repeat changes=%0d sel=%0d want 1/0", changes, src_sel); end
  endtask

`ifdef DISP_HOLD_EN
  // Release at the change edge E, re-press at E+9 so the second advance lands on the E+16 terminal count.
  task automatic test_coincide();
    int t;
    btn_next = 1'b1;
    t = 0;
    while (src_sel !== 2'd1 && t < 20) begin step(1); t++; end
    btn_next = 1'b0;
    checks++; if (src_sel !== 2'd1) begin errors++; $display("FAIL coin_first got %0d want 1", src_sel); end
    step(9);
    src1 = 32'd4444;
    btn_next = 1'b1;
    step(7);
    checks++; if (src_sel !== 2'd2 || num !== 13'd77) begin errors++; $display("FAIL coin_edge sel=%0d num=%0d want 2/77", src_sel, num); end
    src2 = 32'd600;
    step(1);
    checks++; if (num !== 13'd600) begin errors++; $display("FAIL coin_new got %0d want 600", num); end
    btn_next = 1'b0;
    src2 = 32'd601;
    step(6);
    checks++; if (num !== 13'd600) begin errors++; $display("FAIL coin_restart_early got %0d want 600", num); end
    step(1);
    checks++; if (num !== 13'd601) begin errors++; $display("FAIL coin_restart_tc got %0d want 601", num); end
    step(15);
  endtask
`else
  task automatic test_ramp();
    for (int i = 0; i < 20; i++) begin
      src0 = 32'd1000 + 32'(i);
      step(1);
      checks++;
      if (num !== 13'(1000 + i)) begin errors++; $display("FAIL ramp_%0d got %0d want %0d", i, num, 1000 + i); end
    end
  endtask
`endif

  task automatic test_reset_abort();
    src0 = 32'd2222;
    btn_next = 1'b1;
    step(5);
    rst = 1'b1;
    btn_next = 1'b0;
    step(2);
    checks++; if (num !== 13'd0 || src_sel !== 2'd0) begin errors++; $display("FAIL abort_in_reset num=%0d sel=%0d want 0/0", num, src_sel); end
    rst = 1'b0;
    step(20);
    checks++; if (src_sel !== 2'd0) begin errors++; $display("FAIL abort_no_pulse got %0d want 0", src_sel); end
    checks++; if (num !== 13'd2222) begin errors++; $display("FAIL abort_num got %0d want 2222", num); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clamp();
    test_boundary();
    test_wrap();
`ifdef DISP_HOLD_EN
    test_coincide();
`else
    test_ramp();
`endif
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
